alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit; the multi-cycle companion to the single-cycle datapath ALU.
- Implements the full RV32M op set at WIDTH bits: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Execute stage issues through a valid/ready handshake and stalls until the result is accepted.
- Provides a flush for pipeline redirects.

Parameters:
- WIDTH, 32, operand/result width in bits; any even value >= 8.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  abort current operation; synchronous.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- md_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  WIDTH  rs1 value.
- operand_b  in  WIDTH  rs2 value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- Reset (rst_n=0 at an edge): state IDLE, out_valid=0, result=0, counter=0, internal regs cleared. Reset overrides flush and in_valid.
- Flush (flush=1 at an edge, rst_n=1): state IDLE, out_valid=0, result unchanged. Flush wins over a simultaneous in_valid, and no request is accepted that cycle.
- Accept: in_valid & in_ready at an edge latches md_op, operand magnitudes and sign flags. Operands are not sampled afterwards.
- Multiply (shift-add, 1 bit per cycle):
  - Accept moves IDLE to CALC with counter=WIDTH.
  - Each CALC edge performs one step and decrements the counter.
  - The counter reaching 0 moves CALC to DONE, so out_valid is high WIDTH cycles after the accepting edge.
  - Signed ops multiply magnitudes and negate the 2*WIDTH product when the operand signs differ. MULHSU treats only operand_a as signed.
  - MUL returns product[WIDTH-1:0]. MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
- Divide (restoring, 1 quotient bit per cycle): same WIDTH-cycle latency.
  - Signed: quotient negated if the signs differ; remainder takes the dividend's sign; quotient rounds toward zero.
- Special cases resolve at accept, going IDLE to DONE with latency 1:
  - Divide by zero (operand_b=0): DIV/DIVU return all ones; REM/REMU return operand_a.
  - Signed overflow (DIV/REM with operand_a=most-negative, operand_b=all ones): DIV returns operand_a; REM returns 0.
- DONE to IDLE on out_ready=1 at an edge. While out_ready=0, result and out_valid hold stable.
- in_ready=0 in DONE, so there is no back-to-back overlap; the next request is accepted at the earliest one edge after the result handshake.
- result changes only on entering DONE, on reset, or never in IDLE/CALC, so no glitching values appear.
- Arithmetic is modulo 2^WIDTH (or 2^(2*WIDTH) internally). No exceptions are raised.

Optional Feature:
- Macro ALU_MULDIV_FAST_MUL_EN.
- Defined:
  - All four multiply ops use a combinational WIDTH x WIDTH multiplier and go IDLE to DONE with latency 1.
  - Divide is unchanged.
- Undefined:
  - Iterative shift-add multiply with WIDTH-cycle latency as above.
  - No hardware multiplier is inferred.

Test Plan:
- WIDTH=32, MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 32 cycles after accept (1 with FAST_MUL_EN); MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100 b=7 -> 14; REMU -> 2; latency 32.
- DIVU a=5 b=0 -> 0xFFFFFFFF, REMU -> 5, out_valid 1 cycle after accept; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, REM -> 0, latency 1.
- Backpressure: complete a MUL with out_ready=0 for 5 cycles -> out_valid and result stable, in_ready=0 throughout. Raise out_ready -> IDLE next edge; a new request with in_valid held high is accepted one edge later.
- Flush at cycle 10 of a DIV -> IDLE next edge, out_valid never asserts, in_ready=1. A flush coincident with in_valid in IDLE -> request not accepted.
- rst_n=0 for one edge mid-CALC and again in DONE -> out_valid=0, result=0, in_ready=1. A following MULHU runs to a correct result.

Source files
------------

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative RV32M-style multiply/divide unit, WIDTH bits wide.
//               Shift-add multiply and restoring divide, one bit per cycle.
//               Divide-by-zero and signed overflow resolve at accept.
//               Optional macro ALU_MULDIV_FAST_MUL_EN: multiplies use a
//               combinational WIDTH x WIDTH multiplier (IDLE -> DONE at
//               accept); divide is unaffected.
// Ports       : clk, rst_n (sync, active-low), flush (sync abort)
//               in_valid/in_ready, md_op[2:0] (funct3), operand_a, operand_b
//               out_valid/out_ready, result, busy (CALC or DONE)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             r_neg_res;   // product / quotient must be negated
    logic             r_neg_rem;   // remainder takes dividend's sign
    logic [WIDTH-1:0] r_mcand;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_hi;        // partial product high / partial remainder
    logic [WIDTH-1:0] r_lo;        // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0] r_result;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_is_div;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_special_res;

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU leaves rs2 unsigned.
    // MUL's low half is sign-agnostic, so it runs as unsigned.
    assign w_a_signed = (md_op == 3'b001) || (md_op == 3'b010) ||
                        (md_op == 3'b100) || (md_op == 3'b110);
    assign w_b_signed = (md_op == 3'b001) || (md_op == 3'b100) ||
                        (md_op == 3'b110);

    assign w_a_neg = w_a_signed & operand_a[WIDTH-1];
    assign w_b_neg = w_b_signed & operand_b[WIDTH-1];

    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude.
    assign w_mag_a = w_a_neg ? -operand_a : operand_a;
    assign w_mag_b = w_b_neg ? -operand_b : operand_b;

    assign w_is_div   = md_op[2];
    assign w_div_zero = w_is_div && (operand_b == '0);
    assign w_div_ovf  = w_is_div && !md_op[0] &&
                        (operand_a == c_MOST_NEG) && (operand_b == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = md_op[1] ? operand_a : '1;
        else if (w_div_ovf)
            w_special_res = md_op[1] ? '0 : operand_a;
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [2*WIDTH-1:0] w_fast_sgn;
    logic [WIDTH-1:0]   w_fast_res;

    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
    assign w_fast_sgn  = (w_a_neg ^ w_b_neg) ? -w_fast_prod : w_fast_prod;
    assign w_fast_res  = (md_op[1:0] == 2'b00) ? w_fast_sgn[WIDTH-1:0]
                                               : w_fast_sgn[2*WIDTH-1:WIDTH];
`endif

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    // Multiply: add multiplicand on the multiplier LSB, then shift the whole
    // {carry, hi, lo} right one place. After WIDTH steps {hi, lo} = product.
    assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : {WIDTH{1'b0}})};

    // Divide: shift the next dividend bit into the remainder and subtract the
    // divisor when it fits. A restored remainder is always < divisor, so the
    // difference fits in WIDTH bits.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mcand;

    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_op[2]) begin
            w_step_hi = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final result, formed from the last step's outputs
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_sgn;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_sgn = r_neg_res ? -w_prod : w_prod;
    assign w_quot     = r_neg_res ? -w_step_lo : w_step_lo;
    assign w_rem      = r_neg_rem ? -w_step_hi : w_step_hi;

    always_comb begin
        w_final = '0;
        if (r_op[2])
            w_final = r_op[1] ? w_rem : w_quot;
        else if (r_op[1:0] == 2'b00)
            w_final = w_prod_sgn[WIDTH-1:0];
        else
            w_final = w_prod_sgn[2*WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result  <= '0;
        end else if (flush) begin
            // Abort; the last delivered result stays visible.
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op      <= md_op;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_mcand   <= w_is_div ? w_mag_b : w_mag_a;
                        r_hi      <= '0;
                        r_lo      <= w_is_div ? w_mag_a : w_mag_b;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= c_DONE;
                        end
`ifdef ALU_MULDIV_FAST_MUL_EN
                        else if (!w_is_div) begin
                            r_result <= w_fast_res;
                            r_state  <= c_DONE;
                        end
`endif
                        else begin
                            r_cnt   <= c_CNT_INIT;
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_result <= w_final;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready)
                        r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign result    = r_result;

endmodule
`default_nettype wire
